// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS generator/checker pair.
// Holds the checker state encoding, standard tap masks and the
// feedback prediction function used at both ends of the link.
package prbs_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam logic [6:0]  PRBS7_TAPS  = 7'h60;
    localparam logic [14:0] PRBS15_TAPS = 15'h6000;
    localparam logic [30:0] PRBS31_TAPS = 31'h48000000;

    // Next bit predicted by a Fibonacci LFSR: parity of the tapped state bits.
    function automatic logic prbs_pred(input logic [MAX_W-1:0] state,
                                       input logic [MAX_W-1:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// prbs_lfsr_step: one combinational step of a Fibonacci LFSR.
// Ports:
//   state      - current LFSR state (bit 0 holds the most recent bit)
//   bit_in     - external bit to shift in when sel_pred is low
//   sel_pred   - 1: shift in the predicted bit (free-run), 0: shift in bit_in
//   pred       - predicted next bit, XOR-reduce(state & TAPS)
//   next_state - {state[WIDTH-2:0], feedback}
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(PRBS7_TAPS)
) (
    input  logic [WIDTH-1:0] state,
    input  logic             bit_in,
    input  logic             sel_pred,
    output logic             pred,
    output logic [WIDTH-1:0] next_state
);

    always_comb begin
        pred       = prbs_pred(MAX_W'(state), MAX_W'(TAPS));
        next_state = {state[WIDTH-2:0], (sel_pred ? pred : bit_in)};
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver. Seeds a local LFSR from
// the incoming stream, verifies LOCK_CNT consecutive predictions, then
// free-runs and flags/counts bit errors, dropping lock on error bursts.
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   din       - received serial bit
//   din_vld   - din is consumed only when high
//   clr_cnt   - synchronous clear of err_cnt
//   locked    - checker is in LOCKED state
//   err       - one-cycle pulse for a mismatched bit while LOCKED
//   err_cnt   - saturating count of errors seen while LOCKED
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH       = 7,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(PRBS7_TAPS),
    parameter int unsigned      LOCK_CNT    = 16,
    parameter int unsigned      WINDOW      = 64,
    parameter int unsigned      UNLOCK_ERRS = 4,
    parameter int unsigned      ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 din_vld,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned SEED_W = $clog2(WIDTH + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
    localparam int unsigned UERR_W = $clog2(UNLOCK_ERRS + 1);

    chk_state_t           st, st_n;
    logic [WIDTH-1:0]     lfsr, lfsr_n, lfsr_shift;
    logic [SEED_W-1:0]    seed_cnt, seed_cnt_n;
    logic [LOCK_W-1:0]    lock_cnt, lock_cnt_n, lock_cnt_inc;
    logic [WIN_W-1:0]     win_cnt, win_cnt_n, win_cnt_inc;
    logic [UERR_W-1:0]    win_errs, win_errs_n, win_errs_inc;
    logic                 locked_n, err_n;
    logic [ERR_CNT_W-1:0] err_cnt_n;
    logic                 pred, mism;

    // Once locked, the LFSR free-runs on its own prediction so line errors
    // never corrupt the reference sequence.
    prbs_lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state      (lfsr),
        .bit_in     (din),
        .sel_pred   (st == LOCKED),
        .pred       (pred),
        .next_state (lfsr_shift)
    );

    assign mism = din ^ pred;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= SEED;
            lfsr     <= '0;
            seed_cnt <= '0;
            lock_cnt <= '0;
            win_cnt  <= '0;
            win_errs <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            st       <= st_n;
            lfsr     <= lfsr_n;
            seed_cnt <= seed_cnt_n;
            lock_cnt <= lock_cnt_n;
            win_cnt  <= win_cnt_n;
            win_errs <= win_errs_n;
            locked   <= locked_n;
            err      <= err_n;
            err_cnt  <= err_cnt_n;
        end
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        st_n         = st;
        lfsr_n       = lfsr;
        seed_cnt_n   = seed_cnt;
        lock_cnt_n   = lock_cnt;
        win_cnt_n    = win_cnt;
        win_errs_n   = win_errs;
        err_n        = 1'b0;
        err_cnt_n    = err_cnt;
        lock_cnt_inc = lock_cnt + LOCK_W'(1);
        win_cnt_inc  = win_cnt + WIN_W'(1);
        win_errs_inc = win_errs + UERR_W'(mism);

        if (din_vld) begin
            lfsr_n = lfsr_shift;
            unique case (st)
                SEED: begin
                    if (seed_cnt == SEED_W'(WIDTH - 1)) begin
                        seed_cnt_n = '0;
                        // An all-zero seed would lock onto the trivial sequence.
                        if (lfsr_shift != '0) begin
                            st_n       = ACQ;
                            lock_cnt_n = '0;
                        end
                    end else begin
                        seed_cnt_n = seed_cnt + SEED_W'(1);
                    end
                end
                ACQ: begin
                    if (mism) begin
                        st_n       = SEED;
                        seed_cnt_n = '0;
                        lock_cnt_n = '0;
                    end else if (lock_cnt_inc == LOCK_W'(LOCK_CNT)) begin
                        st_n       = LOCKED;
                        lock_cnt_n = '0;
                        win_cnt_n  = '0;
                        win_errs_n = '0;
                    end else begin
                        lock_cnt_n = lock_cnt_inc;
                    end
                end
                LOCKED: begin
                    err_n = mism;
                    if (mism && (err_cnt != '1)) begin
                        err_cnt_n = err_cnt + ERR_CNT_W'(1);
                    end
                    if (win_errs_inc == UERR_W'(UNLOCK_ERRS)) begin
                        st_n       = SEED;
                        seed_cnt_n = '0;
                        win_cnt_n  = '0;
                        win_errs_n = '0;
                    end else if (win_cnt_inc == WIN_W'(WINDOW)) begin
                        win_cnt_n  = '0;
                        win_errs_n = '0;
                    end else begin
                        win_cnt_n  = win_cnt_inc;
                        win_errs_n = win_errs_inc;
                    end
                end
                default: begin
                    st_n       = SEED;
                    seed_cnt_n = '0;
                end
            endcase
        end

        // Counter clear is a register control, not a data event, so it does
        // not wait for din_vld; it overrides a same-edge increment.
        if (clr_cnt) begin
            err_cnt_n = '0;
        end

        locked_n = (st_n == LOCKED);
    end

endmodule
